hmmm_io_port: RTL
=================

# hmmm_io_port

Device-side responder for the core's `IOWaiting`/`IOReady` handshake, serving the HMMM `read` and `write` instructions.

- On a read, it collects two bytes from a host byte stream, assembles a 16-bit value and returns it to the core.
- On a write, it serializes the core's 16-bit value into two bytes on a host byte stream.
- It sits between the core's controller/datapath and the off-chip host bridge. It is the only consumer of `IOWaiting` and the only producer of `IOReady`.

## Interface
Parameters:
- `MSB_FIRST`, default 1. 1: the high byte is transferred first on both streams. 0: the low byte is transferred first.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge
- `reset`  in  1  reset is synchronous and active-high
- `IOWaiting`  in  1  core requests an I/O transfer; held high until it observes `IOReady`
- `IODir`  in  1  0 = read (host to core), 1 = write (core to host); valid while `IOWaiting` is high
- `IOWData`  in  16  write data from the core; valid while `IOWaiting` is high
- `IORData`  out  16  last completed read value; held until the next read completes
- `IOReady`  out  1  one-cycle completion pulse
- `RxData`  in  8  host input byte
- `RxValid`  in  1  host input byte is valid
- `RxReady`  out  1  port accepts an input byte
- `TxData`  out  8  output byte to the host
- `TxValid`  out  1  output byte is valid
- `TxReady`  in  1  host accepts the output byte
- `Busy`  out  1  high in every state except IDLE

## Operation
- States: IDLE, RX_FIRST, RX_SECOND, TX_FIRST, TX_SECOND, DONE.
- IDLE:
  - `IOWaiting`=1 and `IODir`=0: go to RX_FIRST.
  - `IOWaiting`=1 and `IODir`=1: latch `IOWData` into the tx holding register and go to TX_FIRST.
  - Otherwise stay in IDLE.
- Byte transfer rule: a byte transfers on any rising edge where valid and ready are both 1. No transfer occurs otherwise.
- RX_FIRST / RX_SECOND:
  - `RxReady`=1.
  - On a transfer, store `RxData` into the byte lane given by `MSB_FIRST` and advance: RX_FIRST to RX_SECOND, RX_SECOND to DONE.
  - The first byte goes into a staging register.
  - `IORData` updates with both bytes on the edge entering DONE, never earlier.
- TX_FIRST / TX_SECOND:
  - `TxValid`=1.
  - `TxData` carries the high byte first when `MSB_FIRST`=1, the low byte first otherwise.
  - `TxData` is held stable while `TxValid`=1 and `TxReady`=0.
  - On a transfer, advance: TX_FIRST to TX_SECOND, TX_SECOND to DONE.
- DONE: `IOReady`=1 for exactly one cycle, then go unconditionally to IDLE.
- `IODir` and `IOWData` are sampled only in IDLE. Changes during a transfer have no effect.
- Core obligation: `IOWaiting` must be low in the cycle after `IOReady`. The port does not re-check this in DONE.
- `RxReady` and `TxValid` are never high simultaneously. Both are 0 in IDLE and DONE.
- Abort: no mechanism other than `reset`. Deasserting `IOWaiting` mid-transfer does not cancel it.
- Reset values: state IDLE; `IORData`=0; staging and tx holding registers=0; `IOReady`=0, `RxReady`=0, `TxValid`=0, `TxData`=0, `Busy`=0.
- Reset mid-transfer:
  - Any partial byte is discarded and `IORData` is cleared.
  - A byte whose valid/ready handshake coincides with the reset edge is not consumed.
  - Same-edge reset wins over every other transition.

## Timing
- All outputs are registered or decoded from state only. There is no combinational path from `RxValid`, `TxReady` or `IOWaiting` to any output.
- Minimum read latency:
  - `IOWaiting` rises in cycle 0, with the host always valid.
  - `RxReady` in cycles 1–2, `IOReady` in cycle 3.
  - `IORData` is valid from cycle 3 onward.
- Minimum write latency: `TxValid` in cycles 1–2, `IOReady` in cycle 3.
- Each host stall cycle (valid or ready low) adds exactly one cycle.
- Back-to-back I/O: after DONE, the earliest next request is sampled in the IDLE cycle that follows. Minimum spacing is 4 cycles per transfer.

## Test plan
- Read, `MSB_FIRST`=1:
  - Stimulus: host presents 0x12 then 0x34 with `RxValid` always high.
  - Response: `IORData`=0x1234 and `IOReady` pulse in cycle 3; `IORData` holds 0x1234 through a following write.
- Write, `MSB_FIRST`=0:
  - Stimulus: `IOWData`=0xBEEF; `TxReady` low for 2 cycles on the first byte.
  - Response: `TxData`=0xEF held stable for 3 cycles, then 0xBE; `IOReady` in cycle 5.
- Write data sampling:
  - Stimulus: change `IOWData` to 0x0000 the cycle after the write request.
  - Response: bytes sent are still those of the original value.
- Reset mid-read:
  - Stimulus: assert `reset` in RX_SECOND, after 0xAB has been accepted.
  - Response: `IORData`=0, `Busy`=0, no `IOReady`; a following read of 0x5A, 0xA5 returns 0x5AA5.
- Back-to-back operations:
  - Stimulus: read then write then read, each request raised in the IDLE cycle after the previous DONE.
  - Response: three `IOReady` pulses spaced 4 cycles apart; `RxReady` and `TxValid` are never high together.

Source files
------------

// File: rtl/hmmm_io_port.sv
// hmmm_io_port: device-side responder for the HMMM core's IOWaiting/IOReady
// handshake. A read gathers two host bytes into a 16-bit word for the core.
// A write splits the core's 16-bit word into two host bytes.
// MSB_FIRST selects the byte order on both host streams.
module hmmm_io_port #(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        IOWaiting,
  input  logic        IODir,
  input  logic [15:0] IOWData,
  output logic [15:0] IORData,
  output logic        IOReady,
  input  logic [7:0]  RxData,
  input  logic        RxValid,
  output logic        RxReady,
  output logic [7:0]  TxData,
  output logic        TxValid,
  input  logic        TxReady,
  output logic        Busy
);

  typedef enum logic [2:0] {
    IDLE,
    RX_FIRST,
    RX_SECOND,
    TX_FIRST,
    TX_SECOND,
    DONE
  } state_t;

  state_t      state;
  logic [7:0]  rx_stage;  // first received byte, held until the second arrives
  logic [15:0] tx_hold;   // write word captured when the request is accepted

  // Sequencer: every output is a register, loaded together with the state
  // it belongs to, so no host-side or core-side input reaches an output
  // combinationally.
  always_ff @(posedge clk) begin
    // NOTE: state and output registers are all assigned with <=, so each
    // branch reads the values from before this edge. Reset sits first in
    // the block, so it overrides any handshake that lands on the same edge.
    if (reset) begin
      state    <= IDLE;
      rx_stage <= '0;
      tx_hold  <= '0;
      IORData  <= '0;
      IOReady  <= 1'b0;
      RxReady  <= 1'b0;
      TxValid  <= 1'b0;
      TxData   <= '0;
      Busy     <= 1'b0;
    end else begin
      IOReady <= 1'b0;
      unique case (state)
        IDLE: begin
          if (IOWaiting) begin
            Busy <= 1'b1;
            if (!IODir) begin
              state   <= RX_FIRST;
              RxReady <= 1'b1;
            end else begin
              state   <= TX_FIRST;
              tx_hold <= IOWData;
              TxValid <= 1'b1;
              TxData  <= MSB_FIRST ? IOWData[15:8] : IOWData[7:0];
            end
          end
        end

        RX_FIRST: begin
          if (RxValid) begin
            rx_stage <= RxData;
            state    <= RX_SECOND;
          end
        end

        RX_SECOND: begin
          if (RxValid) begin
            // Publish the whole word only once both bytes are in hand.
            IORData <= MSB_FIRST ? {rx_stage, RxData} : {RxData, rx_stage};
            RxReady <= 1'b0;
            IOReady <= 1'b1;
            state   <= DONE;
          end
        end

        TX_FIRST: begin
          if (TxReady) begin
            TxData <= MSB_FIRST ? tx_hold[7:0] : tx_hold[15:8];
            state  <= TX_SECOND;
          end
        end

        TX_SECOND: begin
          if (TxReady) begin
            TxValid <= 1'b0;
            IOReady <= 1'b1;
            state   <= DONE;
          end
        end

        DONE: begin
          // The core drops IOWaiting after seeing IOReady, so IDLE is safe.
          Busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state   <= IDLE;
          RxReady <= 1'b0;
          TxValid <= 1'b0;
          Busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
